// File: rtl/branch_exec.sv
// Branch execution unit: resolves the single buffered conditional branch once both operands are ready,
// pulses done/flush and holds a redirect to fetch until it is acknowledged.
// Opcodes: BEQ=0 BNE=1 BLT=2 BGE=3 BLTU=4 BGEU=5, anything else never taken. Tag value 0 means UNLOCKED.
module branch_exec #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              branch_busy_in,
    input  logic [2:0]        branch_op_in,
    input  logic [TAG_W-1:0]  branch_tagx_in,
    input  logic [TAG_W-1:0]  branch_tagy_in,
    input  logic [WORD_W-1:0] branch_datax_in,
    input  logic [WORD_W-1:0] branch_datay_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [WORD_W-1:0] branch_offset_in,
    output logic              done_out,
    output logic              jump_valid_out,
    output logic [ADDR_W-1:0] jump_pc_out,
    input  logic              jump_ack_in,
    output logic              flush_out,
    output logic [31:0]       branch_cnt_out,
    output logic [31:0]       taken_cnt_out
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EVAL     = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLT  = 3'd2;
    localparam logic [2:0] OP_BGE  = 3'd3;
    localparam logic [2:0] OP_BLTU = 3'd4;
    localparam logic [2:0] OP_BGEU = 3'd5;

    localparam logic [TAG_W-1:0] UNLOCKED = '0;

    function automatic logic branch_taken(input logic [2:0] op,
                                          input logic [WORD_W-1:0] x,
                                          input logic [WORD_W-1:0] y);
        logic signed [WORD_W-1:0] sx;
        logic signed [WORD_W-1:0] sy;
        sx = x;
        sy = y;
        case (op)
            OP_BEQ:  return x == y;
            OP_BNE:  return x != y;
            OP_BLT:  return sx < sy;
            OP_BGE:  return sx >= sy;
            OP_BLTU: return x < y;
            OP_BGEU: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WORD_W-1:0] x_q, x_d;
    logic [WORD_W-1:0] y_q, y_d;
    logic [ADDR_W-1:0] jump_pc_q, jump_pc_d;
    logic [31:0]       branch_cnt_q, branch_cnt_d;
    logic [31:0]       taken_cnt_q, taken_cnt_d;
    logic              taken;
    logic [ADDR_W-1:0] offset_ext;

    assign offset_ext = ADDR_W'($signed(branch_offset_in));
    assign taken      = branch_taken(op_q, x_q, y_q);

    // Outputs decode from state so that rdy=0 freezes (and stretches) them for free.
    assign done_out       = (state_q == S_EVAL);
    assign flush_out      = done_out && taken;
    assign jump_valid_out = flush_out || (state_q == S_REDIRECT);
    assign jump_pc_out    = jump_pc_q;
    assign branch_cnt_out = branch_cnt_q;
    assign taken_cnt_out  = taken_cnt_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        jump_pc_d    = jump_pc_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (branch_busy_in && branch_tagx_in == UNLOCKED && branch_tagy_in == UNLOCKED) begin
                        op_d      = branch_op_in;
                        x_d       = branch_datax_in;
                        y_d       = branch_datay_in;
                        jump_pc_d = pc_in + offset_ext;
                        state_d   = S_EVAL;
                    end
                end
                S_EVAL: begin
                    branch_cnt_d = branch_cnt_q + 32'd1;
                    if (taken) begin
                        taken_cnt_d = taken_cnt_q + 32'd1;
                        state_d     = S_REDIRECT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_REDIRECT: begin
                    if (jump_ack_in) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            jump_pc_q    <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            jump_pc_q    <= jump_pc_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    // Operand latches are only observed in EVAL, after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        x_q  <= x_d;
        y_q  <= y_d;
    end

endmodule

// File: tb/tb_branch_exec.sv
// Randomized and directed bench for branch_exec, checked against a transaction-level reference model.
module tb_branch_exec;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int TAG_W  = 4;

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLT  = 3'd2;
    localparam logic [2:0] OP_BGE  = 3'd3;
    localparam logic [2:0] OP_BLTU = 3'd4;
    localparam logic [2:0] OP_BGEU = 3'd5;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              branch_busy_in;
    logic [2:0]        branch_op_in;
    logic [TAG_W-1:0]  branch_tagx_in;
    logic [TAG_W-1:0]  branch_tagy_in;
    logic [WORD_W-1:0] branch_datax_in;
    logic [WORD_W-1:0] branch_datay_in;
    logic [ADDR_W-1:0] pc_in;
    logic [WORD_W-1:0] branch_offset_in;
    logic              done_out;
    logic              jump_valid_out;
    logic [ADDR_W-1:0] jump_pc_out;
    logic              jump_ack_in;
    logic              flush_out;
    logic [31:0]       branch_cnt_out;
    logic [31:0]       taken_cnt_out;

    int        n_checks = 0;
    int        n_pass   = 0;
    bit [31:0] exp_bcnt = 0;
    bit [31:0] exp_tcnt = 0;

    always #5 clk = ~clk;

    branch_exec #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .branch_busy_in   (branch_busy_in),
        .branch_op_in     (branch_op_in),
        .branch_tagx_in   (branch_tagx_in),
        .branch_tagy_in   (branch_tagy_in),
        .branch_datax_in  (branch_datax_in),
        .branch_datay_in  (branch_datay_in),
        .pc_in            (pc_in),
        .branch_offset_in (branch_offset_in),
        .done_out         (done_out),
        .jump_valid_out   (jump_valid_out),
        .jump_pc_out      (jump_pc_out),
        .jump_ack_in      (jump_ack_in),
        .flush_out        (flush_out),
        .branch_cnt_out   (branch_cnt_out),
        .taken_cnt_out    (taken_cnt_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: interpret operands as plain integers and compare.
    function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint ux, uy, sx, sy;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= 64'sd2147483648) ? ux - 64'sd4294967296 : ux;
        sy = (uy >= 64'sd2147483648) ? uy - 64'sd4294967296 : uy;
        case (op)
            OP_BEQ:  return ux == uy;
            OP_BNE:  return ux != uy;
            OP_BLT:  return sx < sy;
            OP_BGE:  return sx >= sy;
            OP_BLTU: return ux < uy;
            OP_BGEU: return ux >= uy;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] off);
        longint t;
        t = (longint'(pc) + longint'(off)) % 64'sd4294967296;
        return t[31:0];
    endfunction

    task automatic check_counts;
        check_eq("branch_cnt", branch_cnt_out, exp_bcnt);
        check_eq("taken_cnt", taken_cnt_out, exp_tcnt);
    endtask

    task automatic run_branch(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] pc, input logic [31:0] off,
                              input int lock, input int ack_dly, input bit stop_in_redirect);
        bit          tk;
        logic [31:0] tgt;
        tk  = ref_taken(op, x, y);
        tgt = ref_target(pc, off);
        branch_busy_in   = 1'b1;
        branch_op_in     = op;
        branch_datax_in  = x;
        branch_datay_in  = y;
        pc_in            = pc;
        branch_offset_in = off;
        branch_tagy_in   = '0;
        branch_tagx_in   = (lock > 0) ? 4'h5 : 4'h0;
        for (int i = 0; i < lock; i++) begin
            tick;
            check_eq("locked_done", 32'(done_out), 0);
            check_eq("locked_jv", 32'(jump_valid_out), 0);
            if (i == lock - 1) branch_tagx_in = '0;
        end
        tick;
        check_eq("eval_done", 32'(done_out), 1);
        check_eq("eval_flush", 32'(flush_out), 32'(tk));
        check_eq("eval_jv", 32'(jump_valid_out), 32'(tk));
        if (tk) check_eq("eval_jpc", jump_pc_out, tgt);
        branch_busy_in  = 1'b0;
        branch_tagx_in  = 4'h9;
        branch_datax_in = $urandom;
        jump_ack_in     = 1'($urandom_range(0, 1));
        tick;
        jump_ack_in = 1'b0;
        exp_bcnt++;
        if (tk) exp_tcnt++;
        check_eq("post_done", 32'(done_out), 0);
        check_eq("post_flush", 32'(flush_out), 0);
        check_counts();
        if (tk) begin
            check_eq("redir_jv", 32'(jump_valid_out), 1);
            check_eq("redir_jpc", jump_pc_out, tgt);
            if (stop_in_redirect) return;
            for (int i = 0; i < ack_dly; i++) begin
                tick;
                check_eq("hold_jv", 32'(jump_valid_out), 1);
                check_eq("hold_jpc", jump_pc_out, tgt);
            end
            jump_ack_in = 1'b1;
            tick;
            jump_ack_in = 1'b0;
            check_eq("ack_jv", 32'(jump_valid_out), 0);
            check_eq("ack_done", 32'(done_out), 0);
        end else begin
            check_eq("nt_jv", 32'(jump_valid_out), 0);
        end
    endtask

    task automatic check_reset_state;
        check_eq("rst_done", 32'(done_out), 0);
        check_eq("rst_jv", 32'(jump_valid_out), 0);
        check_eq("rst_flush", 32'(flush_out), 0);
        check_eq("rst_jpc", jump_pc_out, 0);
        check_counts();
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        rst              = 1'b0;
        rdy              = 1'b1;
        branch_busy_in   = 1'b0;
        branch_op_in     = '0;
        branch_tagx_in   = '0;
        branch_tagy_in   = '0;
        branch_datax_in  = '0;
        branch_datay_in  = '0;
        pc_in            = '0;
        branch_offset_in = '0;
        jump_ack_in      = 1'b0;
        tick;
        tick;
        check_reset_state();
        rst = 1'b1;

        run_branch(OP_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 0, 3, 1'b0);
        run_branch(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF0, 0, 0, 1'b0);
        run_branch(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 0, 0, 1'b0);
        run_branch(OP_BNE, 32'd7, 32'd7, 32'h400, 32'h8, 4, 0, 1'b0);
        run_branch(OP_BGE, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h20, 0, 1, 1'b0);
        run_branch(3'd7, 32'd1, 32'd1, 32'h500, 32'h4, 0, 0, 1'b0);

        // A frozen done pulse stretches without counting twice.
        branch_busy_in  = 1'b1;
        branch_op_in    = OP_BEQ;
        branch_tagx_in  = '0;
        branch_tagy_in  = '0;
        branch_datax_in = 32'd1;
        branch_datay_in = 32'd2;
        tick;
        check_eq("frz_done0", 32'(done_out), 1);
        branch_busy_in = 1'b0;
        rdy = 1'b0;
        tick;
        tick;
        check_eq("frz_done2", 32'(done_out), 1);
        check_counts();
        rdy = 1'b1;
        tick;
        exp_bcnt++;
        check_eq("frz_done_end", 32'(done_out), 0);
        check_counts();

        for (int n = 0; n < 40; n++) begin
            rx = $urandom;
            ry = ($urandom_range(0, 3) == 0) ? rx : $urandom;
            run_branch(3'($urandom_range(0, 7)), rx, ry, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Freeze in REDIRECT with ack asserted, then reset out of it.
        run_branch(OP_BNE, 32'd1, 32'd2, 32'h1000, 32'h44, 0, 0, 1'b1);
        rdy = 1'b0;
        jump_ack_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_eq("rdy0_jv", 32'(jump_valid_out), 1);
            check_eq("rdy0_jpc", jump_pc_out, 32'h1044);
        end
        check_counts();
        rdy = 1'b1;
        jump_ack_in = 1'b0;
        rst = 1'b0;
        tick;
        exp_bcnt = 0;
        exp_tcnt = 0;
        check_reset_state();
        rst = 1'b1;
        run_branch(OP_BGEU, 32'd9, 32'd2, 32'h80, 32'h10, 1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
